// File: rtl/button_step_ctrl_pkg.sv
// Shared definitions for the button-driven step/run controller.
// Holds the debouncer state encoding, default timing constants and a counter-width helper.
package button_step_ctrl_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEFAULT_RUN_DIV         = 50000000;
    localparam int unsigned STEP_COUNT_W            = 16;

    typedef enum logic [1:0] {
        DB_IDLE           = 2'd0,
        DB_BOUNCE_PRESS   = 2'd1,
        DB_PRESSED        = 2'd2,
        DB_BOUNCE_RELEASE = 2'd3
    } db_state_e;

    // Bits needed to hold any value 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 32'd2) begin
            return 32'd1;
        end
        return $unsigned($clog2(max_val + 32'd1));
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus press/release debounce FSM for one pushbutton.
// press_c is a single-cycle event on the accepted press; releases are silent.
module button_debouncer
    import button_step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press_c
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic             sync_meta;
    logic             sync_q;
    db_state_e        state;
    db_state_e        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Synchronizer: the raw pin is only ever seen through sync_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync_q    <= sync_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DB_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The counter tracks consecutive cycles spent in a bounce state at the new level.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        press_c    = 1'b0;
        case (state)
            DB_IDLE: begin
                if (sync_q) begin
                    state_next = DB_BOUNCE_PRESS;
                    cnt_next   = '0;
                end
            end
            DB_BOUNCE_PRESS: begin
                if (!sync_q) begin
                    state_next = DB_IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = DB_PRESSED;
                    cnt_next   = '0;
                    press_c    = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DB_PRESSED: begin
                if (!sync_q) begin
                    state_next = DB_BOUNCE_RELEASE;
                    cnt_next   = '0;
                end
            end
            DB_BOUNCE_RELEASE: begin
                if (sync_q) begin
                    state_next = DB_PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = DB_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = DB_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_step_ctrl.sv
// Step/run clock-enable controller: a debounced step button issues single StepEn pulses,
// a debounced mode button toggles a free-run mode that pulses StepEn every RUN_DIV cycles.
module button_step_ctrl
    import button_step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned RUN_DIV         = DEFAULT_RUN_DIV
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    BtnStep,
    input  logic                    BtnMode,
    output logic                    StepEn,
    output logic                    RunMode,
    output logic [STEP_COUNT_W-1:0] StepCount
);

    localparam int unsigned       RATE_W    = cnt_width(RUN_DIV);
    localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(RUN_DIV - 32'd1);

    logic              step_press_c;
    logic              mode_press_c;
    logic              run_mode_next;
    logic              step_en_next;
    logic [RATE_W-1:0] rate_cnt;
    logic [RATE_W-1:0] rate_next;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk    (Clk),
        .reset  (Reset),
        .btn    (BtnStep),
        .press_c(step_press_c)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode_db (
        .clk    (Clk),
        .reset  (Reset),
        .btn    (BtnMode),
        .press_c(mode_press_c)
    );

    // A mode press wins over a same-cycle step press and restarts the rate counter.
    always_comb begin
        run_mode_next = RunMode ^ mode_press_c;
        rate_next     = '0;
        step_en_next  = 1'b0;
        if (run_mode_next) begin
            if (!mode_press_c && (rate_cnt != RATE_LAST)) begin
                rate_next = rate_cnt + RATE_W'(1);
            end
            step_en_next = (rate_next == RATE_LAST);
        end else begin
            step_en_next = step_press_c && !mode_press_c;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            RunMode   <= 1'b0;
            rate_cnt  <= '0;
            StepEn    <= 1'b0;
            StepCount <= '0;
        end else begin
            RunMode   <= run_mode_next;
            rate_cnt  <= rate_next;
            StepEn    <= step_en_next;
            StepCount <= StepCount + STEP_COUNT_W'(StepEn);
        end
    end

endmodule

// File: doc/button_step_ctrl.md
BUTTON_STEP_CTRL -- requirements
Module: button_step_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high, with ports named Clk and Reset.
REQ-002 The block SHALL expose these parameters:
- DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles needed to accept an edge (10 ms at 100 MHz).
- RUN_DIV, default 50000000: StepEn period in run mode.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- Clk  input  1  board clock.
- Reset  input  1  sync active-high reset.
- BtnStep  input  1  raw asynchronous step pushbutton.
- BtnMode  input  1  raw asynchronous mode pushbutton.
- StepEn  output  1  one-cycle clock-enable pulse to the fetch unit.
- RunMode  output  1  0 = single-step, 1 = free-run.
- StepCount  output  16  count of StepEn pulses, for the display.

Function
REQ-004 Each button SHALL pass through a two-flop synchronizer before any other logic, adding 2 cycles of latency.
REQ-005 Each debouncer SHALL implement an FSM with four states:
- IDLE: on sync=1, go to BOUNCE_PRESS and clear the counter.
- BOUNCE_PRESS: after DEBOUNCE_CYCLES consecutive sync=1 cycles, go to PRESSED; any sync=0 returns to IDLE with the counter cleared.
- PRESSED: on sync=0, go to BOUNCE_RELEASE and clear the counter.
- BOUNCE_RELEASE: after DEBOUNCE_CYCLES consecutive sync=0 cycles, go to IDLE; any sync=1 returns to PRESSED.
REQ-006 Each debouncer SHALL emit a one-cycle press event on the BOUNCE_PRESS->PRESSED transition only; release SHALL produce no event.
REQ-007 A held button SHALL produce exactly one press event, regardless of hold length.
REQ-008 RunMode SHALL toggle in the cycle after a BtnMode press event.
REQ-009 In step mode, StepEn SHALL assert for exactly one cycle, the cycle after a BtnStep press event.
REQ-010 In run mode, the rate counter SHALL count 0..RUN_DIV-1 and wrap to 0; StepEn SHALL assert in the cycle the counter equals RUN_DIV-1.
REQ-011 The rate counter SHALL clear to 0 whenever RunMode changes, so the first run pulse arrives RUN_DIV cycles after entry.
REQ-012 BtnStep press events SHALL be ignored in run mode.
REQ-013 If BtnMode and BtnStep press events occur in the same cycle, the mode toggle SHALL take effect and the step event SHALL be discarded.
REQ-014 StepCount SHALL increment by 1 in the cycle after each StepEn and wrap from 0xFFFF to 0x0000.
REQ-015 StepEn SHALL never assert on two consecutive cycles when RUN_DIV >= 2.
REQ-016 RUN_DIV = 1 SHALL make StepEn constantly high in run mode.
REQ-017 All counters SHALL be wide enough to hold DEBOUNCE_CYCLES and RUN_DIV respectively (computed with clog2).

Reset
REQ-018 On Reset, the outputs SHALL take these values: StepEn=0, RunMode=0, StepCount=0.
REQ-019 On Reset, both debouncers SHALL go to IDLE, and all counters and synchronizer flops SHALL clear to 0.
REQ-020 A Reset asserted mid-debounce or mid-period SHALL abort the operation with no press event or StepEn emitted.
REQ-021 A button still held when Reset deasserts SHALL be debounced afresh and yield one press event.

Structure
REQ-022 The debouncer SHALL be a sub-module, button_debouncer, containing the synchronizer and FSM, instantiated twice.
REQ-023 The debouncer state encoding and the default DEBOUNCE_CYCLES and RUN_DIV constants SHALL live in a shared package.
REQ-024 All sequential logic SHALL be clocked on the rising edge of Clk; there SHALL be no derived clocks.

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=8)
REQ-025 Step press: hold BtnStep high 20 cycles -> exactly one StepEn, 2+4+1 cycles after the rise; StepCount=1.
REQ-026 Bounce: BtnStep toggles 1,0,1,0 every cycle, then settles high -> no StepEn during the toggling; one StepEn after 4 stable cycles.
REQ-027 Run mode: one BtnMode press -> RunMode=1; StepEn every 8 cycles; StepCount=5 after 40 cycles.
REQ-028 Simultaneous: BtnMode and BtnStep rise in the same cycle from step mode -> RunMode=1; no StepEn for the next 7 cycles.
REQ-029 Wrap: preload StepCount via 65535 steps, then one more step -> StepCount=0x0000.
REQ-030 Reset mid-debounce: Reset asserted in BOUNCE_PRESS -> no StepEn; all outputs 0; a held button yields one StepEn 7 cycles after Reset deasserts.
